// File: rtl/imem_pkg.sv
// Shared constants and grant-select type for the instruction memory arbiter.
package imem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        FETCH  = 2'd1,
        LOADER = 2'd2
    } gnt_sel_t;

endpackage

// File: rtl/imem_rr_pick.sv
// Two-way round-robin winner select with a loader lock override.
module imem_rr_pick
    import imem_pkg::*;
(
    input  logic     f_req,
    input  logic     l_req,
    input  gnt_sel_t last_gnt,
    input  logic     lock,
    output gnt_sel_t sel
);

    // On contention the side that did not win last takes the slot, unless the loader lock holds it.
    always_comb begin
        sel = NONE;
        if (f_req && l_req) begin
            if (lock || (last_gnt == FETCH)) begin
                sel = LOADER;
            end else begin
                sel = FETCH;
            end
        end else if (f_req) begin
            sel = FETCH;
        end else if (l_req) begin
            sel = LOADER;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between CPU fetch and a loader/debug port,
// with combinational grants and registered one-cycle-latency responses.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [DATA_W-1:0] f_rdata_o,
    output logic              f_err_o,
    input  logic              l_req_i,
    input  logic              l_we_i,
    input  logic [ADDR_W-1:0] l_addr_i,
    input  logic [DATA_W-1:0] l_wdata_i,
    input  logic              l_lock_i,
    output logic              l_gnt_o,
    output logic              l_rvalid_o,
    output logic [DATA_W-1:0] l_rdata_o,
    output logic              l_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int OFF_W = $clog2(WORD_BYTES);
    localparam int CNT_W = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);

    gnt_sel_t         last_gnt;
    gnt_sel_t         sel;
    logic [CNT_W-1:0] lock_cnt;
    logic             lock_in_force;
    logic             f_acc_err;
    logic             l_acc_err;

    function automatic logic addr_err(input logic [ADDR_W-1:0] addr);
        return (addr[OFF_W-1:0] != '0) || ((addr >> OFF_W) >= ADDR_W'(DEPTH));
    endfunction

    assign f_acc_err     = addr_err(f_addr_i);
    assign l_acc_err     = addr_err(l_addr_i);
    assign lock_in_force = l_lock_i && l_req_i && (last_gnt == LOADER)
                           && (lock_cnt < CNT_W'(MAX_LOCK));

    imem_rr_pick u_pick (
        .f_req    (f_req_i),
        .l_req    (l_req_i),
        .last_gnt (last_gnt),
        .lock     (lock_in_force),
        .sel      (sel)
    );

    assign f_gnt_o = (sel == FETCH);
    assign l_gnt_o = (sel == LOADER);

    // Memory bus follows the winner; erroneous loader writes never reach the array.
    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        case (sel)
            FETCH: begin
                mem_addr_o = f_addr_i;
            end
            LOADER: begin
                mem_addr_o  = l_addr_i;
                mem_we_o    = l_we_i && !l_acc_err;
                mem_wdata_o = l_wdata_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt <= LOADER;
            lock_cnt <= '0;
        end else begin
            if (sel != NONE) begin
                last_gnt <= sel;
            end
            if ((sel == FETCH) || !l_lock_i) begin
                lock_cnt <= '0;
            end else if ((sel == LOADER) && f_req_i && (lock_cnt != CNT_W'(MAX_LOCK))) begin
                lock_cnt <= lock_cnt + CNT_W'(1);
            end
        end
    end

    // rvalid pulses for one cycle; rdata/err hold until that side's next response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f_rvalid_o <= 1'b0;
            f_rdata_o  <= '0;
            f_err_o    <= 1'b0;
            l_rvalid_o <= 1'b0;
            l_rdata_o  <= '0;
            l_err_o    <= 1'b0;
        end else begin
            f_rvalid_o <= f_gnt_o;
            l_rvalid_o <= l_gnt_o;
            if (f_gnt_o) begin
                f_rdata_o <= f_acc_err ? '0 : mem_rdata_i;
                f_err_o   <= f_acc_err;
            end
            if (l_gnt_o) begin
                l_rdata_o <= (l_acc_err || l_we_i) ? '0 : mem_rdata_i;
                l_err_o   <= l_acc_err;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: vector table, hand-written corner sequences
// and randomized traffic against a behavioural model with its own memory image.
module tb_imem_arbiter;

    localparam int DEPTH    = 32;
    localparam int MAX_LOCK = 8;
    localparam int IDX_W    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst_i;
    logic        f_req_i;
    logic [31:0] f_addr_i;
    logic        f_gnt_o;
    logic        f_rvalid_o;
    logic [31:0] f_rdata_o;
    logic        f_err_o;
    logic        l_req_i;
    logic        l_we_i;
    logic [31:0] l_addr_i;
    logic [31:0] l_wdata_i;
    logic        l_lock_i;
    logic        l_gnt_o;
    logic        l_rvalid_o;
    logic [31:0] l_rdata_o;
    logic        l_err_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    imem_arbiter #(.DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .f_req_i     (f_req_i),
        .f_addr_i    (f_addr_i),
        .f_gnt_o     (f_gnt_o),
        .f_rvalid_o  (f_rvalid_o),
        .f_rdata_o   (f_rdata_o),
        .f_err_o     (f_err_o),
        .l_req_i     (l_req_i),
        .l_we_i      (l_we_i),
        .l_addr_i    (l_addr_i),
        .l_wdata_i   (l_wdata_i),
        .l_lock_i    (l_lock_i),
        .l_gnt_o     (l_gnt_o),
        .l_rvalid_o  (l_rvalid_o),
        .l_rdata_o   (l_rdata_o),
        .l_err_o     (l_err_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
    endfunction

    // Instruction memory array the DUT drives: combinational read, clocked write.
    logic [31:0] env_mem [DEPTH];
    logic        init_mem;

    assign mem_rdata_i = ((mem_addr_o >> 2) < DEPTH) ? env_mem[mem_addr_o[IDX_W+1:2]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < DEPTH; i++) env_mem[i] <= pat(i);
        end else if (mem_we_o && ((mem_addr_o >> 2) < DEPTH)) begin
            env_mem[mem_addr_o[IDX_W+1:2]] <= mem_wdata_o;
        end
    end

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        lr;
        logic        lw;
        logic [31:0] la;
        logic [31:0] lwd;
        logic        lk;
        logic        exp_fg;
        logic        exp_lg;
        logic        exp_we;
    } vec_t;

    function automatic vec_t mk(input logic fr, input logic [31:0] fa, input logic lr,
                                input logic lw, input logic [31:0] la, input logic [31:0] lwd,
                                input logic lk, input logic efg, input logic elg, input logic ewe);
        vec_t v;
        v.fr = fr; v.fa = fa; v.lr = lr; v.lw = lw; v.la = la; v.lwd = lwd; v.lk = lk;
        v.exp_fg = efg; v.exp_lg = elg; v.exp_we = ewe;
        return v;
    endfunction

    int tests = 0;
    int fails = 0;

    // Reference model state: who won last (1 fetch, 2 loader), lock run length, memory image, held responses.
    int          m_last;
    int          m_cnt;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] h_frdata;
    logic [31:0] h_lrdata;
    logic        h_ferr;
    logic        h_lerr;
    int          last_win;
    logic        cap_fg;
    logic        cap_lg;
    logic        cap_we;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic is_err(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic model_reset();
        m_last   = 2;
        m_cnt    = 0;
        h_frdata = '0;
        h_lrdata = '0;
        h_ferr   = 1'b0;
        h_lerr   = 1'b0;
        last_win = 0;
    endtask

    // One arbitration cycle: drive, check grant and bus, clock, check responses.
    task automatic apply_stimulus(input logic fr, input logic [31:0] fa, input logic lr,
                                  input logic lw, input logic [31:0] la, input logic [31:0] lwd,
                                  input logic lk);
        bit          lock;
        int          win;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_wd;
        bit          err;
        @(negedge clk);
        f_req_i = fr; f_addr_i = fa;
        l_req_i = lr; l_we_i = lw; l_addr_i = la; l_wdata_i = lwd; l_lock_i = lk;
        #1;
        lock = lk && lr && (m_last == 2) && (m_cnt < MAX_LOCK);
        if (fr && lr)  win = (lock || (m_last == 1)) ? 2 : 1;
        else if (fr)   win = 1;
        else if (lr)   win = 2;
        else           win = 0;
        e_addr = '0; e_we = 1'b0; e_wd = '0;
        if (win == 1) e_addr = fa;
        if (win == 2) begin
            e_addr = la; e_we = lw && !is_err(la); e_wd = lwd;
        end
        cap_fg = f_gnt_o; cap_lg = l_gnt_o; cap_we = mem_we_o;
        check_bit("f_gnt", f_gnt_o, win == 1);
        check_bit("l_gnt", l_gnt_o, win == 2);
        check_output("mem_addr", mem_addr_o, e_addr);
        check_bit("mem_we", mem_we_o, e_we);
        check_output("mem_wdata", mem_wdata_o, e_wd);
        if (win == 1) begin
            err      = is_err(fa);
            h_frdata = err ? 32'h0 : ref_mem[int'(fa >> 2)];
            h_ferr   = err;
        end else if (win == 2) begin
            err      = is_err(la);
            h_lrdata = (err || lw) ? 32'h0 : ref_mem[int'(la >> 2)];
            h_lerr   = err;
            if (!err && lw) ref_mem[int'(la >> 2)] = lwd;
        end
        if ((win == 1) || !lk)          m_cnt = 0;
        else if ((win == 2) && fr)      m_cnt = m_cnt + 1;
        if (win != 0)                   m_last = win;
        last_win = win;
        @(posedge clk);
        #1;
        check_bit("f_rvalid", f_rvalid_o, win == 1);
        check_output("f_rdata", f_rdata_o, h_frdata);
        check_bit("f_err", f_err_o, h_ferr);
        check_bit("l_rvalid", l_rvalid_o, win == 2);
        check_output("l_rdata", l_rdata_o, h_lrdata);
        check_bit("l_err", l_err_o, h_lerr);
    endtask

    vec_t vecs [11];

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic        fr, lr, lw, lk;
        logic [31:0] fa, la, lwd;

        rst_i = 1'b1; init_mem = 1'b1;
        f_req_i = 0; f_addr_i = '0; l_req_i = 0; l_we_i = 0;
        l_addr_i = '0; l_wdata_i = '0; l_lock_i = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_f_rvalid", f_rvalid_o, 1'b0);
        check_output("rst_f_rdata", f_rdata_o, 32'h0);
        check_bit("rst_f_err", f_err_o, 1'b0);
        check_bit("rst_l_rvalid", l_rvalid_o, 1'b0);
        check_output("rst_l_rdata", l_rdata_o, 32'h0);
        check_bit("rst_l_err", l_err_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0; init_mem = 1'b0;

        // fetch-only, ties, write-then-read, error accesses, idle
        vecs[0]  = mk(1, 32'h08, 0, 0, 32'h00, 32'h0,         0, 1, 0, 0);
        vecs[1]  = mk(1, 32'h08, 0, 0, 32'h00, 32'h0,         0, 1, 0, 0);
        vecs[2]  = mk(1, 32'h08, 0, 0, 32'h00, 32'h0,         0, 1, 0, 0);
        vecs[3]  = mk(1, 32'h04, 1, 0, 32'h0C, 32'h0,         0, 0, 1, 0);
        vecs[4]  = mk(1, 32'h04, 1, 0, 32'h0C, 32'h0,         0, 1, 0, 0);
        vecs[5]  = mk(1, 32'h04, 1, 0, 32'h0C, 32'h0,         0, 0, 1, 0);
        vecs[6]  = mk(0, 32'h00, 1, 1, 32'h10, 32'hDEADBEEF,  0, 0, 1, 1);
        vecs[7]  = mk(1, 32'h10, 0, 0, 32'h00, 32'h0,         0, 1, 0, 0);
        vecs[8]  = mk(1, 32'h06, 0, 0, 32'h00, 32'h0,         0, 1, 0, 0);
        vecs[9]  = mk(0, 32'h00, 1, 1, 32'h80, 32'h12345678,  0, 0, 1, 0);
        vecs[10] = mk(0, 32'h00, 0, 0, 32'h00, 32'h0,         0, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].fr, vecs[i].fa, vecs[i].lr, vecs[i].lw,
                           vecs[i].la, vecs[i].lwd, vecs[i].lk);
            check_bit($sformatf("tbl%0d_f_gnt", i), cap_fg, vecs[i].exp_fg);
            check_bit($sformatf("tbl%0d_l_gnt", i), cap_lg, vecs[i].exp_lg);
            check_bit($sformatf("tbl%0d_mem_we", i), cap_we, vecs[i].exp_we);
        end
        check_output("tbl_write_seen", f_rdata_o, 32'h0);

        // Locked loader burst against a waiting fetch: 8 loader grants, then fetch, twice.
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(1, 32'h00, 1, 0, 32'h04, 32'h0, 1);
            check_bit($sformatf("lock%0d_f_gnt", i), cap_fg, (i % 9) == 8);
            check_bit($sformatf("lock%0d_l_gnt", i), cap_lg, (i % 9) != 8);
        end

        // Randomized traffic obeying the hold-until-granted handshake.
        fr = 0; lr = 0; fa = '0; la = '0; lw = 0; lwd = '0; lk = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(fr && (last_win != 1))) begin
                fr = ($urandom_range(0, 3) != 0);
                fa = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
            end
            if (!(lr && (last_win != 2))) begin
                lr  = ($urandom_range(0, 2) != 0);
                lw  = ($urandom_range(0, 2) == 0);
                la  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
                lwd = $urandom;
            end
            lk = ($urandom_range(0, 3) != 0);
            apply_stimulus(fr, fa, lr, lw, la, lwd, lk);
        end

        // Reset mid-stream with a grant pending.
        apply_stimulus(1, 32'h08, 0, 0, 32'h0, 32'h0, 0);
        check_bit("pre_rst_f_rvalid", f_rvalid_o, 1'b1);
        @(negedge clk);
        f_req_i = 1; f_addr_i = 32'h0C; l_req_i = 1; l_we_i = 0; l_addr_i = 32'h14; l_lock_i = 0;
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check_bit("mid_rst_f_rvalid", f_rvalid_o, 1'b0);
        check_bit("mid_rst_l_rvalid", l_rvalid_o, 1'b0);
        check_output("mid_rst_f_rdata", f_rdata_o, 32'h0);
        @(posedge clk);
        #1;
        check_bit("in_rst_f_rvalid", f_rvalid_o, 1'b0);
        check_bit("in_rst_l_rvalid", l_rvalid_o, 1'b0);
        @(negedge clk);
        f_req_i = 0; l_req_i = 0; rst_i = 1'b0;
        @(posedge clk);
        #1;
        check_bit("post_rst_f_rvalid", f_rvalid_o, 1'b0);
        check_bit("post_rst_l_rvalid", l_rvalid_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 32'h0C, 1, 0, 32'h14, 32'h0, 0);
            check_bit($sformatf("alt%0d_f_gnt", i), cap_fg, (i % 2) == 0);
            check_bit($sformatf("alt%0d_l_gnt", i), cap_lg, (i % 2) == 1);
        end

        apply_stimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            check_output($sformatf("mem_word%0d", i), env_mem[i], ref_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
